// File: rtl/filter_seq_if.sv
// Link between the coefficient/sample sequencer and the IIR filter core it drives.
// The master side is the sequencer; the slave side is the filter.
interface filter_seq_if;
  logic signed [9:0]  coef_out;
  logic               coef_load;
  logic               clear_states;
  logic signed [15:0] sig_in;
  logic               start;
  logic               filt_done;
  logic signed [15:0] filt_sig;

  modport master (
    output coef_out, coef_load, clear_states, sig_in, start,
    input  filt_done, filt_sig
  );

  modport slave (
    input  coef_out, coef_load, clear_states, sig_in, start,
    output filt_done, filt_sig
  );
endinterface

// File: rtl/filter_seq.sv
// Per-sample sequencer: double-buffered coefficient bank, optional state clear, filter run, result capture.
// Define FILTER_SEQ_CLEAR_EN to enable the CLEAR state and the clr_req input.
module filter_seq (
  input  logic               clk,
  input  logic               rst_an,
  input  logic               coef_wr,
  input  logic [3:0]         coef_addr,
  input  logic signed [9:0]  coef_data,
  input  logic               commit,
  input  logic               clr_req,
  input  logic               sample_tick,
  input  logic signed [15:0] exc_in,
  filter_seq_if.master       filt,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               overrun
);

  localparam int unsigned NCOEF = 12;
  typedef logic signed [9:0] coef_t;

`ifdef FILTER_SEQ_CLEAR_EN
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_OUT} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_OUT} state_e;
`endif

  state_e             state_q, state_d;
  coef_t              shadow_q [NCOEF];
  coef_t              shadow_d [NCOEF];
  coef_t              active_q [NCOEF];
  coef_t              active_d [NCOEF];
  logic               pending_q, pending_d;
  logic               clr_q, clr_d;
  logic               defer_q, defer_d;
  logic               defer_clr_q, defer_clr_d;
  logic               overrun_q, overrun_d;
  logic [3:0]         idx_q, idx_d;
  logic signed [15:0] sig_in_q, sig_in_d;
  logic signed [15:0] sample_out_q, sample_out_d;
  logic               clr_in;
  logic               in_load;

`ifdef FILTER_SEQ_CLEAR_EN
  assign clr_in = clr_req;
`else
  logic unused_clr_req;
  assign unused_clr_req = clr_req;
  assign clr_in         = 1'b0;
`endif

  assign in_load = (state_q == S_LOAD);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    clr_d        = clr_q;
    defer_d      = defer_q;
    defer_clr_d  = defer_clr_q;
    overrun_d    = overrun_q;
    idx_d        = idx_q;
    sig_in_d     = sig_in_q;
    sample_out_d = sample_out_q;

    if (coef_wr && (coef_addr < 4'(NCOEF))) shadow_d[coef_addr] = coef_data;

    // A commit arriving mid-LOAD must not disturb the coefficients being streamed out.
    if (commit) begin
      if (in_load) begin
        defer_d     = 1'b1;
        defer_clr_d = defer_clr_q | clr_in;
      end else begin
        active_d  = shadow_q;
        pending_d = 1'b1;
        clr_d     = clr_q | clr_in;
      end
    end

    if (sample_tick && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          sig_in_d = exc_in;
          idx_d    = '0;
          if (!pending_d)   state_d = S_RUN;
`ifdef FILTER_SEQ_CLEAR_EN
          else if (clr_d)   state_d = S_CLEAR;
`endif
          else              state_d = S_LOAD;
        end
      end
`ifdef FILTER_SEQ_CLEAR_EN
      S_CLEAR: state_d = S_LOAD;
`endif
      S_LOAD: begin
        if (idx_q == 4'(NCOEF - 1)) begin
          state_d     = S_RUN;
          pending_d   = defer_d;
          clr_d       = defer_clr_d;
          if (defer_d) active_d = shadow_q;
          defer_d     = 1'b0;
          defer_clr_d = 1'b0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_RUN: begin
        if (filt.filt_done) begin
          sample_out_d = filt.filt_sig;
          state_d      = S_OUT;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses <= so every flop samples pre-edge values; the comb block above uses = only.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q      <= S_IDLE;
      // NOTE: both coefficient banks are reset because a never-committed bank must read as zero.
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      pending_q    <= 1'b0;
      clr_q        <= 1'b0;
      defer_q      <= 1'b0;
      defer_clr_q  <= 1'b0;
      overrun_q    <= 1'b0;
      idx_q        <= '0;
      sig_in_q     <= '0;
      sample_out_q <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      clr_q        <= clr_d;
      defer_q      <= defer_d;
      defer_clr_q  <= defer_clr_d;
      overrun_q    <= overrun_d;
      idx_q        <= idx_d;
      sig_in_q     <= sig_in_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign filt.coef_load = in_load;
  assign filt.coef_out  = in_load ? active_q[idx_q] : '0;
  assign filt.start     = (state_q == S_RUN);
  assign filt.sig_in    = sig_in_q;
`ifdef FILTER_SEQ_CLEAR_EN
  assign filt.clear_states = (state_q == S_CLEAR);
`else
  assign filt.clear_states = 1'b0;
`endif

  assign sample_out   = sample_out_q;
  assign sample_valid = (state_q == S_OUT);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_filter_seq.sv
// Self-checking bench for filter_seq: cycle-offset reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_filter_seq;

`ifdef FILTER_SEQ_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_an;
  logic               coef_wr;
  logic [3:0]         coef_addr;
  logic signed [9:0]  coef_data;
  logic               commit;
  logic               clr_req;
  logic               sample_tick;
  logic signed [15:0] exc_in;
  logic               tb_done;
  logic signed [15:0] tb_fsig;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               overrun;

  always #5 clk = ~clk;

  filter_seq_if fif ();
  assign fif.filt_done = tb_done;
  assign fif.filt_sig  = tb_fsig;

  filter_seq dut (
    .clk          (clk),
    .rst_an       (rst_an),
    .coef_wr      (coef_wr),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .commit       (commit),
    .clr_req      (clr_req),
    .sample_tick  (sample_tick),
    .exc_in       (exc_in),
    .filt         (fif),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks cycles since the accepted tick instead of FSM states.
  logic [9:0]  m_shadow [12];
  logic [9:0]  m_active [12];
  bit          m_pending, m_clr, m_defer, m_defer_clr, m_overrun, m_busy, m_done, m_clear;
  int          m_t, m_pre;
  logic [15:0] m_sig, m_out;

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending = 0; m_clr = 0; m_defer = 0; m_defer_clr = 0; m_overrun = 0;
    m_busy = 0; m_done = 0; m_clear = 0; m_t = 0; m_pre = 0;
    m_sig = '0; m_out = '0;
  endtask

  function automatic bit model_in_load();
    return m_busy && (m_pre > 0) && (m_t >= m_pre - 11) && (m_t <= m_pre);
  endfunction

  task automatic model_step();
    bit in_load;
    in_load = model_in_load();
    if (commit) begin
      if (in_load) begin
        m_defer     = 1;
        m_defer_clr = m_defer_clr | (clr_req & CLR_EN);
      end else begin
        m_active  = m_shadow;
        m_pending = 1;
        m_clr     = m_clr | (clr_req & CLR_EN);
      end
    end
    if (!m_busy) begin
      if (sample_tick) begin
        m_busy  = 1;
        m_t     = 1;
        m_done  = 0;
        m_sig   = exc_in;
        m_clear = m_pending && m_clr && CLR_EN;
        m_pre   = !m_pending ? 0 : (m_clear ? 13 : 12);
      end
    end else begin
      if (sample_tick) m_overrun = 1;
      if (in_load && m_t == m_pre) begin
        m_pending = m_defer;
        m_clr     = m_defer_clr;
        if (m_defer) m_active = m_shadow;
        m_defer     = 0;
        m_defer_clr = 0;
      end
      if (m_t > m_pre) begin
        if (m_done) m_busy = 0;
        else if (tb_done) begin
          m_done = 1;
          m_out  = tb_fsig;
        end
      end
      m_t++;
    end
    if (coef_wr && coef_addr < 4'd12) m_shadow[coef_addr] = coef_data;
  endtask

  always @(negedge clk) begin
    bit         e_load, e_clear, e_start, e_valid;
    logic [9:0] e_coef;
    if (!rst_an) model_reset();
    e_load = 0; e_clear = 0; e_start = 0; e_valid = 0; e_coef = '0;
    if (m_busy) begin
      if (m_clear && m_t == 1) e_clear = 1;
      if (model_in_load()) begin
        e_load = 1;
        e_coef = m_active[m_t - (m_pre - 11)];
      end
      if (m_t > m_pre) begin
        if (m_done) e_valid = 1;
        else        e_start = 1;
      end
    end
    check("m_coef_load",    {31'b0, fif.coef_load},    {31'b0, e_load});
    check("m_coef_out",     {22'b0, fif.coef_out},     {22'b0, e_coef});
    check("m_clear_states", {31'b0, fif.clear_states}, {31'b0, e_clear});
    check("m_start",        {31'b0, fif.start},        {31'b0, e_start});
    check("m_sig_in",       {16'b0, fif.sig_in},       {16'b0, m_sig});
    check("m_sample_out",   {16'b0, sample_out},       {16'b0, m_out});
    check("m_sample_valid", {31'b0, sample_valid},     {31'b0, e_valid});
    check("m_overrun",      {31'b0, overrun},          {31'b0, m_overrun});
    if (rst_an) model_step();
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [15:0] x);
    sample_tick = 1'b1;
    exc_in      = x;
    cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_commit(input logic clr);
    commit  = 1'b1;
    clr_req = clr;
    cyc(1);
    commit  = 1'b0;
    clr_req = 1'b0;
  endtask

  // Waits (bounded) for start, then returns the filter result and lets OUT pass.
  task automatic run_to_done(input logic [15:0] res);
    int k = 0;
    while (!fif.start && k < 40) begin
      cyc(1);
      k++;
    end
    check("start_seen", {31'b0, fif.start}, 32'd1);
    tb_done = 1'b1;
    tb_fsig = res;
    cyc(1);
    tb_done = 1'b0;
    check("done_valid", {31'b0, sample_valid}, 32'd1);
    check("done_value", {16'b0, sample_out}, {16'b0, res});
    cyc(1);
  endtask

  logic [9:0] tbl [12];

  initial begin
    tbl = '{10'h1C9, 10'h3E4, 10'h0B8, 10'h3CF, 10'h038, 10'h280,
            10'h395, 10'h3BF, 10'h335, 10'h3BF, 10'h000, 10'h000};
    rst_an = 1'b0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    commit = 1'b0; clr_req = 1'b0; sample_tick = 1'b0; exc_in = '0;
    tb_done = 1'b0; tb_fsig = '0;
    cyc(3);
    check("rst_overrun",   {31'b0, overrun},       32'd0);
    check("rst_coef_load", {31'b0, fif.coef_load}, 32'd0);
    check("rst_start",     {31'b0, fif.start},     32'd0);
    rst_an = 1'b1;
    cyc(2);

    // filt_done outside RUN is ignored
    tb_done = 1'b1; tb_fsig = 16'hBEEF;
    cyc(1);
    tb_done = 1'b0;
    cyc(1);
    check("idle_done_valid", {31'b0, sample_valid}, 32'd0);
    check("idle_done_out",   {16'b0, sample_out},   32'd0);

    // first tick after reset: straight to RUN
    tick(16'h0010);
    check("run_start",   {31'b0, fif.start},     32'd1);
    check("run_sig_in",  {16'b0, fif.sig_in},    32'h0010);
    check("run_no_load", {31'b0, fif.coef_load}, 32'd0);
    cyc(2);
    tb_done = 1'b1; tb_fsig = 16'h1234;
    cyc(1);
    tb_done = 1'b0;
    check("out_valid", {31'b0, sample_valid}, 32'd1);
    check("out_value", {16'b0, sample_out},   32'h1234);
    check("out_start", {31'b0, fif.start},    32'd0);
    cyc(1);
    check("out_valid_1cyc", {31'b0, sample_valid}, 32'd0);

    // full coefficient load, plus an ignored write to address 13
    for (int i = 0; i < 12; i++) begin
      coef_wr = 1'b1; coef_addr = 4'(i); coef_data = tbl[i];
      cyc(1);
    end
    coef_addr = 4'd13; coef_data = 10'h155;
    cyc(1);
    coef_wr = 1'b0;
    pulse_commit(1'b0);
    cyc(1);
    tick(16'h0020);
    for (int i = 0; i < 12; i++) begin
      check("load_flag",  {31'b0, fif.coef_load}, 32'd1);
      check("load_coef",  {22'b0, fif.coef_out},  {22'b0, tbl[i]});
      cyc(1);
    end
    check("load_then_start", {31'b0, fif.start},    32'd1);
    check("coef_zero_idle",  {22'b0, fif.coef_out}, 32'd0);
    run_to_done(16'h0ABC);

    // tick while busy is dropped and sets a sticky overrun
    tick(16'h0030);
    check("no_overrun_yet", {31'b0, overrun}, 32'd0);
    tick(16'h0031);
    check("overrun_set",    {31'b0, overrun},    32'd1);
    check("overrun_sig_in", {16'b0, fif.sig_in}, 32'h0030);
    run_to_done(16'h0777);
    check("overrun_sticky", {31'b0, overrun}, 32'd1);

    // commit and tick in the same IDLE cycle load the new set
    coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 10'h2AA;
    cyc(1);
    coef_wr = 1'b0;
    commit = 1'b1;
    tick(16'h0040);
    commit = 1'b0;
    check("same_cyc_load", {31'b0, fif.coef_load}, 32'd1);
    check("same_cyc_coef", {22'b0, fif.coef_out},  32'h2AA);
    run_to_done(16'h0042);

    // commit during LOAD is deferred to the next tick
    pulse_commit(1'b0);
    tick(16'h0050);
    cyc(1);
    coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 10'h111;
    cyc(1);
    coef_wr = 1'b0;
    commit = 1'b1;
    cyc(1);
    commit = 1'b0;
    check("defer_keeps_bank", {22'b0, fif.coef_out}, 32'h3CF);
    run_to_done(16'h0055);
    tick(16'h0060);
    check("defer_pending_load", {31'b0, fif.coef_load}, 32'd1);
    check("defer_new_coef",     {22'b0, fif.coef_out},  32'h111);
    run_to_done(16'h0066);

    // commit with clr_req
    pulse_commit(1'b1);
    tick(16'h0070);
`ifdef FILTER_SEQ_CLEAR_EN
    check("clr_first",     {31'b0, fif.clear_states}, 32'd1);
    check("clr_no_load",   {31'b0, fif.coef_load},    32'd0);
    cyc(1);
    check("clr_one_cycle", {31'b0, fif.clear_states}, 32'd0);
    check("clr_then_load", {31'b0, fif.coef_load},    32'd1);
`else
    check("noclr_clear", {31'b0, fif.clear_states}, 32'd0);
    check("noclr_load",  {31'b0, fif.coef_load},    32'd1);
`endif
    run_to_done(16'h0077);

    // reset during LOAD cycle 5
    pulse_commit(1'b0);
    tick(16'h0080);
    cyc(4);
    rst_an = 1'b0;
    #1;
    check("mid_rst_load",    {31'b0, fif.coef_load}, 32'd0);
    check("mid_rst_coef",    {22'b0, fif.coef_out},  32'd0);
    check("mid_rst_out",     {16'b0, sample_out},    32'd0);
    check("mid_rst_sig_in",  {16'b0, fif.sig_in},    32'd0);
    check("mid_rst_overrun", {31'b0, overrun},       32'd0);
    cyc(1);
    rst_an = 1'b1;
    cyc(1);
    tick(16'h0090);
    check("post_rst_run",     {31'b0, fif.start},     32'd1);
    check("post_rst_no_load", {31'b0, fif.coef_load}, 32'd0);
    run_to_done(16'h0099);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_seq.md
FILTER_SEQ -- requirements
Module: filter_seq

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst_an  input  1  asynchronous active-low reset.
REQ-003 coef_wr  input  1  shadow-buffer write strobe.
REQ-004 coef_addr  input  4  shadow index 0..11 (section s: a at 2s-2, b at 2s-1).
REQ-005 coef_data  input  10  signed coefficient to write.
REQ-006 commit  input  1  one-cycle pulse: shadow set is complete, load at next tick.
REQ-007 clr_req  input  1  sampled with commit: also clear filter states.
REQ-008 sample_tick  input  1  one-cycle sample-rate strobe.
REQ-009 exc_in  input  16  signed excitation sample, captured on accepted tick.
REQ-010 coef_out  output  10  coefficient to filter coef_in.
REQ-011 coef_load  output  1  to filter coef_load.
REQ-012 clear_states  output  1  to filter clear_states.
REQ-013 sig_in  output  16  to filter sig_in.
REQ-014 start  output  1  to filter start.
REQ-015 filt_done  input  1  from filter done.
REQ-016 filt_sig  input  16  from filter sig_out.
REQ-017 sample_out  output  16  signed filtered sample.
REQ-018 sample_valid  output  1  one-cycle qualifier for sample_out.
REQ-019 overrun  output  1  sticky: a tick was dropped while busy.

Function
REQ-020 Twelve 10-bit shadow registers SHALL be written on coef_wr; coef_addr 12..15 SHALL be ignored.
REQ-021 commit SHALL copy shadow into an active bank in the same cycle and set a pending flag (plus clr flag from clr_req); later shadow writes SHALL NOT alter the active bank.
REQ-022 States: IDLE, CLEAR, LOAD, RUN, OUT.
REQ-023 IDLE + sample_tick: capture exc_in into sig_in; go CLEAR if pending and clr flag, LOAD if pending only, else RUN.
REQ-024 CLEAR: clear_states=1 for exactly one cycle, then LOAD.
REQ-025 LOAD: coef_load=1 for exactly 12 consecutive cycles, coef_out = active[0..11] in order; pending and clr flags cleared on exit; then RUN.
REQ-026 RUN: start=1 from entry until filt_done sampled 1; then OUT.
REQ-027 OUT: start=0, sample_out<=filt_sig as sampled with filt_done, sample_valid=1 for one cycle, return IDLE.
REQ-028 Latency: tick without pending -> start high next cycle; with pending -> first coef_load next cycle, start 13 cycles after tick (14 with clear).
REQ-029 commit and sample_tick in same IDLE cycle: the new set SHALL be loaded for that tick.
REQ-030 commit outside IDLE: set pending for the next accepted tick; a second commit overwrites the active bank only when not in LOAD (deferred to LOAD exit otherwise).
REQ-031 sample_tick outside IDLE SHALL be dropped and set overrun; overrun cleared only by reset.
REQ-032 filt_done while not in RUN SHALL be ignored.
REQ-033 coef_out SHALL be 0 whenever coef_load=0.

Reset
REQ-034 rst_an low SHALL force IDLE and zero all outputs, shadow, active bank, pending, clr flags and overrun, including mid-LOAD or mid-RUN.
REQ-035 First tick after reset without a commit SHALL run with all-zero coefficients never loaded (RUN directly).

Configuration
REQ-036 Macro FILTER_SEQ_CLEAR_EN: defined -> CLEAR state and clr_req behave as above; undefined -> clr_req ignored, clear_states tied 0, CLEAR state absent.

Verification
REQ-037 Write 0x1C9,0x3E4,0x0B8,0x3CF,0x038,0x280,0x395,0x3BF,0x335,0x3BF,0,0 at addr 0..11, commit, tick -> 12 coef_load cycles carrying that order, then start.
REQ-038 Tick with exc_in=0x0010, no pending -> sig_in=0x0010, start next cycle; filt_done with filt_sig=0x1234 -> sample_out=0x1234, sample_valid one cycle.
REQ-039 Tick during RUN -> dropped, overrun=1 persists until reset.
REQ-040 Commit with clr_req=1 (macro defined) -> one clear_states cycle precedes the 12 loads; macro undefined -> no clear_states.
REQ-041 Shadow write addr 13 data 0x155 then commit -> loaded sequence unchanged.
REQ-042 rst_an low during LOAD cycle 5 -> all outputs 0; next tick goes straight to RUN.
